// File: rtl/spi_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_pkg
// Purpose  : Opcodes, FSM state encoding and helpers for spi_cmd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
    localparam logic [OP_W-1:0] OP_WRITE  = 4'h1;
    localparam logic [OP_W-1:0] OP_READ   = 4'h2;
    localparam logic [OP_W-1:0] OP_STATUS = 4'h3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_LEN      = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_RD_ISSUE = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_STAT     = 3'd6
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_sequencer_if
// Purpose  : RX/TX word streams and single-port memory bus of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_cmd_sequencer_if #(
    parameter int W      = 32,
    parameter int ADDR_W = 8
);
    logic [W-1:0]      rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [W-1:0]      tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [W-1:0]      mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [W-1:0]      mem_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_rdata,
        output rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_rdata,
        input  rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_sequencer
// Purpose  : Parses SPI command frames and runs burst write/read/status
//            transactions against a single-port register/buffer memory.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int W      = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    spi_cmd_sequencer_if.master bus,
    input  logic                frame_abort,
    output logic                busy,
    output logic [7:0]          err_cnt
);

    state_e            state_q,     state_d;
    logic              rd_q,        rd_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [LEN_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [W-1:0]      mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;
    logic [W-1:0]      tx_data_q,   tx_data_d;
    logic              tx_valid_q,  tx_valid_d;
    logic [7:0]        err_q,       err_d;

    logic              rx_accept;
    logic              rx_pop;
    logic              tx_pop;
    logic              abort;
    logic [OP_W-1:0]   opcode;

    // IDLE holds off one cycle while the final burst write is still on the bus
    always_comb begin
        rx_accept = 1'b0;
        case (state_q)
            ST_IDLE:                        rx_accept = !mem_we_q;
            ST_ADDR, ST_LEN, ST_WR_DATA:    rx_accept = 1'b1;
            default:                        rx_accept = 1'b0;
        endcase
        if (rst) begin
            rx_accept = 1'b0;
        end
    end

    assign rx_pop = bus.rx_valid && rx_accept;
    assign tx_pop = tx_valid_q && bus.tx_ready;
    assign abort  = frame_abort && (state_q != ST_IDLE);
    assign opcode = bus.rx_data[W-1 -: OP_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        err_d       = err_q;

        if (abort) begin
            // Any word popped in this cycle is dropped along with the frame
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            err_d      = sat_inc8(err_q);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_pop) begin
                        case (opcode)
                            OP_NOP: begin
                                state_d = ST_IDLE;
                            end
                            OP_WRITE: begin
                                rd_d    = 1'b0;
                                state_d = ST_ADDR;
                            end
                            OP_READ: begin
                                rd_d    = 1'b1;
                                state_d = ST_ADDR;
                            end
                            OP_STATUS: begin
                                tx_data_d      = '0;
                                tx_data_d[7:0] = err_q;
                                tx_valid_d     = 1'b1;
                                state_d        = ST_STAT;
                            end
                            default: begin
                                err_d = sat_inc8(err_q);
                            end
                        endcase
                    end
                end

                ST_ADDR: begin
                    if (rx_pop) begin
                        addr_d  = bus.rx_data[ADDR_W-1:0];
                        state_d = ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (rx_pop) begin
                        cnt_d = bus.rx_data[LEN_W-1:0];
                        if (rd_q) begin
                            mem_addr_d = addr_q;
                            state_d    = ST_RD_ISSUE;
                        end else begin
                            state_d = ST_WR_DATA;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (rx_pop) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = bus.rx_data;
                        addr_d      = addr_q + 1'b1;
                        cnt_d       = cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end

                ST_RD_ISSUE: begin
                    state_d = ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    // First cycle here is the read-data slot; later cycles wait on TX
                    if (!tx_valid_q) begin
                        tx_data_d  = bus.mem_rdata;
                        tx_valid_d = 1'b1;
                    end else if (bus.tx_ready) begin
                        tx_valid_d = 1'b0;
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            addr_d     = addr_q + 1'b1;
                            mem_addr_d = addr_q + 1'b1;
                            cnt_d      = cnt_q - 1'b1;
                            state_d    = ST_RD_ISSUE;
                        end
                    end
                end

                ST_STAT: begin
                    if (tx_pop) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready  = rx_accept;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = (state_q == ST_RD_ISSUE);
    assign busy          = (state_q != ST_IDLE);
    assign err_cnt       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_sequencer
// Purpose  : Randomized self-checking bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_sequencer;

    localparam int W      = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_abort;
    logic       busy;
    logic [7:0] err_cnt;

    spi_cmd_sequencer_if #(.W(W), .ADDR_W(ADDR_W)) bus ();

    spi_cmd_sequencer #(.W(W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_abort (frame_abort),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_err = 8'd0;

    logic [W-1:0] mem     [256];
    logic [W-1:0] ref_mem [256];

    // Memory peer: one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    logic [39:0]  wr_log [$];
    logic [W-1:0] tx_log [$];
    int           re_cnt = 0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_tx;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we) wr_log.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.mem_re) re_cnt++;
            if (bus.tx_valid && bus.tx_ready) tx_log.push_back(bus.tx_data);
            if (prev_stall) begin
                n_cmp++;
                if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_tx) begin
                    n_bad++;
                    $display("FAIL tx_stall_hold: valid=%b data=%h required valid=1 data=%h",
                             bus.tx_valid, bus.tx_data, prev_tx);
                end
            end
        end
        prev_stall = !rst && !frame_abort && bus.tx_valid && !bus.tx_ready;
        prev_tx    = bus.tx_data;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [W-1:0] w);
        bit ok;
        ok = 1'b0;
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        bus.rx_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_pop_timeout: rx_ready=%b required 1 within 200 cycles", bus.rx_ready);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] lf);
        logic [39:0]       exp_q [$];
        logic [W-1:0]      w;
        logic [ADDR_W-1:0] ad;
        int                bad_idx;
        wr_log.delete();
        push({4'h1, 28'($urandom)});
        push({24'($urandom), a});
        push({24'($urandom), lf});
        for (int i = 0; i <= int'(lf); i++) begin
            w  = $urandom;
            ad = a + i[ADDR_W-1:0];
            exp_q.push_back({ad, w});
            ref_mem[ad] = w;
            push(w);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_last_rx_ready: rx_ready=%b required 0", bus.rx_ready);
        end
        repeat (3) step();
        n_cmp++;
        if (wr_log.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL wr_count: got %0d writes required %0d", wr_log.size(), exp_q.size());
        end else begin
            bad_idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (wr_log[k] !== exp_q[k]) begin
                    bad_idx = k;
                    break;
                end
            end
            n_cmp++;
            if (bad_idx >= 0) begin
                n_bad++;
                $display("FAIL wr_data[%0d]: got addr_data=%h required %h",
                         bad_idx, wr_log[bad_idx], exp_q[bad_idx]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || err_cnt !== exp_err) begin
            n_bad++;
            $display("FAIL wr_end_state: busy=%b err=%0d required busy=0 err=%0d", busy, err_cnt, exp_err);
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] lf, input bit rnd);
        int           n;
        int           bad_idx;
        logic [W-1:0] exp_w;
        n = int'(lf) + 1;
        tx_log.delete();
        re_cnt = 0;
        bus.tx_ready = 1'b1;
        push({4'h2, 28'($urandom)});
        push({24'($urandom), a});
        push({24'($urandom), lf});
        for (int c = 0; c < n * 20 + 50 && tx_log.size() < n; c++) begin
            bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        bus.tx_ready = 1'b1;
        repeat (6) step();
        n_cmp++;
        if (tx_log.size() != n) begin
            n_bad++;
            $display("FAIL rd_count: got %0d words required %0d", tx_log.size(), n);
        end else begin
            bad_idx = -1;
            for (int k = 0; k < n; k++) begin
                if (tx_log[k] !== ref_mem[8'(a + k[ADDR_W-1:0])]) begin
                    bad_idx = k;
                    break;
                end
            end
            n_cmp++;
            if (bad_idx >= 0) begin
                exp_w = ref_mem[8'(a + bad_idx[ADDR_W-1:0])];
                n_bad++;
                $display("FAIL rd_data[%0d]: got %h required %h", bad_idx, tx_log[bad_idx], exp_w);
            end
        end
        n_cmp++;
        if (re_cnt != n || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_strobes: mem_re=%0d busy=%b required mem_re=%0d busy=0", re_cnt, busy, n);
        end
    endtask

    task automatic check_status();
        tx_log.delete();
        bus.tx_ready = 1'b1;
        push({4'h3, 28'($urandom)});
        for (int c = 0; c < 20 && tx_log.size() < 1; c++) step();
        step();
        n_cmp++;
        if (tx_log.size() != 1 || tx_log[0] !== {24'h0, exp_err} || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL status_word: got %0d words first=%h busy=%b required 1 word %h busy=0",
                     tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 32'hx, busy, {24'h0, exp_err});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_abort = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.rx_ready !== 1'b0 || bus.tx_valid !== 1'b0 || bus.tx_data !== '0 ||
            bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || bus.mem_addr !== '0 ||
            bus.mem_wdata !== '0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_state: rdy=%b txv=%b txd=%h we=%b re=%b addr=%h wd=%h busy=%b err=%0d required all 0",
                     bus.rx_ready, bus.tx_valid, bus.tx_data, bus.mem_we, bus.mem_re,
                     bus.mem_addr, bus.mem_wdata, busy, err_cnt);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_burst();
        do_write(8'h10, 8'h03);
    endtask

    task automatic test_read_burst();
        do_read(8'h12, 8'h01, 1'b0);
    endtask

    task automatic test_read_stall();
        logic [ADDR_W-1:0] a;
        a = 8'($urandom);
        tx_log.delete();
        re_cnt = 0;
        bus.tx_ready = 1'b1;
        push({4'h2, 28'($urandom)});
        push({24'($urandom), a});
        push({24'($urandom), 8'h02});
        for (int c = 0; c < 50 && tx_log.size() < 1; c++) step();
        bus.tx_ready = 1'b0;
        repeat (12) step();
        n_cmp++;
        if (bus.tx_valid !== 1'b1 || tx_log.size() != 1 || re_cnt != 2) begin
            n_bad++;
            $display("FAIL rd_stall_state: txv=%b words=%0d mem_re=%0d required 1/1/2",
                     bus.tx_valid, tx_log.size(), re_cnt);
        end
        bus.tx_ready = 1'b1;
        for (int c = 0; c < 50 && tx_log.size() < 3; c++) step();
        repeat (6) step();
        n_cmp++;
        if (tx_log.size() != 3 || re_cnt != 3) begin
            n_bad++;
            $display("FAIL rd_stall_count: words=%0d mem_re=%0d required 3/3", tx_log.size(), re_cnt);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (tx_log[k] !== ref_mem[8'(a + k[ADDR_W-1:0])]) begin
                    n_bad++;
                    $display("FAIL rd_stall_data[%0d]: got %h required %h",
                             k, tx_log[k], ref_mem[8'(a + k[ADDR_W-1:0])]);
                end
            end
        end
    endtask

    task automatic test_bad_opcode();
        push({4'h7, 28'($urandom)});
        exp_err = 8'd1;
        @(negedge clk);
        n_cmp++;
        if (err_cnt !== exp_err || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_opcode: err=%0d busy=%b required err=%0d busy=0", err_cnt, busy, exp_err);
        end
        step();
        check_status();
    endtask

    task automatic test_abort();
        logic [W-1:0] w [3];
        logic [W-1:0] w2;
        logic [ADDR_W-1:0] a;
        wr_log.delete();
        push({4'h1, 28'($urandom)});
        push({24'($urandom), 8'hFE});
        push({24'($urandom), 8'h07});
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            ref_mem[8'(8'hFE + i[7:0])] = w[i];
            push(w[i]);
        end
        frame_abort = 1'b1;
        step();
        frame_abort = 1'b0;
        exp_err = exp_err + 8'd1;
        repeat (3) step();
        n_cmp++;
        if (wr_log.size() != 3) begin
            n_bad++;
            $display("FAIL abort_wr_count: got %0d writes required 3", wr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (wr_log[i] !== {8'(8'hFE + i[7:0]), w[i]}) begin
                    n_bad++;
                    $display("FAIL abort_wr[%0d]: got %h required %h", i, wr_log[i], {8'(8'hFE + i[7:0]), w[i]});
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || err_cnt !== exp_err) begin
            n_bad++;
            $display("FAIL abort_state: busy=%b err=%0d required busy=0 err=%0d", busy, err_cnt, exp_err);
        end
        push({4'h0, 28'($urandom)});
        frame_abort = 1'b1;
        step();
        frame_abort = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || err_cnt !== exp_err || wr_log.size() != 3) begin
            n_bad++;
            $display("FAIL idle_nop_abort: busy=%b err=%0d writes=%0d required 0/%0d/3",
                     busy, err_cnt, wr_log.size(), exp_err);
        end
        // Abort coinciding with a data pop drops that word
        a = 8'($urandom);
        wr_log.delete();
        push({4'h1, 28'($urandom)});
        push({24'($urandom), a});
        push({24'($urandom), 8'h03});
        w[0] = $urandom;
        ref_mem[a] = w[0];
        push(w[0]);
        w2 = $urandom;
        bus.rx_data = w2; bus.rx_valid = 1'b1; frame_abort = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pop_ready: rx_ready=%b required 1", bus.rx_ready);
        end
        step();
        bus.rx_valid = 1'b0; frame_abort = 1'b0;
        exp_err = exp_err + 8'd1;
        repeat (3) step();
        n_cmp++;
        if (wr_log.size() != 1 || wr_log[0] !== {a, w[0]} || err_cnt !== exp_err || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_pop: writes=%0d err=%0d busy=%b required 1 write %h err=%0d busy=0",
                     wr_log.size(), err_cnt, busy, {a, w[0]}, exp_err);
        end
        // Abort during a stalled read drops tx_valid and issues no further reads
        re_cnt = 0;
        bus.tx_ready = 1'b0;
        push({4'h2, 28'($urandom)});
        push({24'($urandom), 8'($urandom)});
        push({24'($urandom), 8'h03});
        for (int c = 0; c < 50 && bus.tx_valid !== 1'b1; c++) step();
        frame_abort = 1'b1;
        step();
        frame_abort = 1'b0;
        exp_err = exp_err + 8'd1;
        @(negedge clk);
        n_cmp++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== exp_err) begin
            n_bad++;
            $display("FAIL abort_read: txv=%b busy=%b err=%0d required 0/0/%0d", bus.tx_valid, busy, err_cnt, exp_err);
        end
        repeat (5) step();
        n_cmp++;
        if (re_cnt != 1) begin
            n_bad++;
            $display("FAIL abort_read_re: mem_re=%0d required 1", re_cnt);
        end
        bus.tx_ready = 1'b1;
    endtask

    task automatic test_random_frames();
        int kind;
        for (int f = 0; f < 14; f++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: do_write(8'($urandom), 8'($urandom_range(0, 7)));
                1: do_read(8'($urandom), 8'($urandom_range(0, 7)), 1'b1);
                2: check_status();
                default: begin
                    push({4'h0, 28'($urandom)});
                    @(negedge clk);
                    n_cmp++;
                    if (busy !== 1'b0 || err_cnt !== exp_err) begin
                        n_bad++;
                        $display("FAIL nop: busy=%b err=%0d required 0/%0d", busy, err_cnt, exp_err);
                    end
                    step();
                end
            endcase
        end
        do_write(8'($urandom), 8'hFF);
        do_read(8'($urandom), 8'hFF, 1'b1);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            push({4'($urandom_range(4, 15)), 28'($urandom)});
            exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
        end
        @(negedge clk);
        n_cmp++;
        if (err_cnt !== exp_err) begin
            n_bad++;
            $display("FAIL err_saturate: err=%0d required %0d", err_cnt, exp_err);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        bus.tx_ready = 1'b0;
        push({4'h2, 28'($urandom)});
        push({24'($urandom), 8'($urandom)});
        push({24'($urandom), 8'h05});
        for (int c = 0; c < 50 && bus.tx_valid !== 1'b1; c++) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mid_read: txv=%b busy=%b err=%0d required 0/0/0", bus.tx_valid, busy, err_cnt);
        end
        step();
        rst = 1'b0;
        exp_err = 8'd0;
        step();
        check_status();
        do_read(8'h10, 8'h03, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_stall();
        test_bad_opcode();
        test_abort();
        test_random_frames();
        test_saturate();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
